pending_encoder: RTL and testbench

//  Encoder-side counterpart of tree_decoder: collects one-hot/multi-hot event pulses

---
 rtl/utils_pkg.sv | 11 +
 rtl/priority_encoder.sv | 27 ++
 rtl/pending_encoder.sv | 117 +++++++++++
 tb/tb_pending_encoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/utils_pkg.sv
// rtl/utils_pkg.sv - shared helpers for select-index encoders and decoders
// Purpose: index-width helper shared by tree_decoder and pending_encoder.
// Ports: none (package).
package utils_pkg;

  // Width of a binary index over w lines; a single line still gets one bit.
  function automatic int sel_width(int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// rtl/priority_encoder.sv - combinational lowest-set-bit encoder
// Purpose: report the index of the lowest set bit of data_i.
// Ports:
//   data_i   in  INPUT_WIDTH  request vector
//   index_o  out SEL_W        index of lowest set bit (0 when none)
//   found_o  out 1            any bit set
module priority_encoder
  import utils_pkg::*;
#(
  parameter int INPUT_WIDTH = 8,
  localparam int SEL_W = sel_width(INPUT_WIDTH)
) (
  input  logic [INPUT_WIDTH-1:0] data_i,
  output logic [SEL_W-1:0]       index_o,
  output logic                   found_o
);

  always_comb begin
    index_o = '0;
    found_o = |data_i;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
      if (data_i[i]) index_o = SEL_W'(i);
    end
  end

endmodule

// File: rtl/pending_encoder.sv
// rtl/pending_encoder.sv - pending event set drained as indices on a valid/ready stream
// Purpose: accumulate event pulses into a pending set and offer one index per transfer,
//          lowest-first or round-robin.
// Ports:
//   clk_i       in  1            clock
//   rst_ni      in  1            async reset, active low
//   enable_i    in  1            sample data_i when high
//   data_i      in  INPUT_WIDTH  event pulses
//   clear_i     in  1            sync flush of pending set and output stage
//   select_o    out SEL_W        offered index
//   valid_o     out 1            select_o holds an event
//   ready_i     in  1            consumer accept
//   pending_o   out INPUT_WIDTH  pending set (excludes offered index)
//   overflow_o  out 1            event merged into an already-pending bit
module pending_encoder
  import utils_pkg::*;
#(
  parameter int INPUT_WIDTH = 8,
  parameter bit ROUND_ROBIN = 1'b0,
  localparam int SEL_W = sel_width(INPUT_WIDTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [INPUT_WIDTH-1:0] data_i,
  input  logic                   clear_i,
  output logic [SEL_W-1:0]       select_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [INPUT_WIDTH-1:0] pending_o,
  output logic                   overflow_o
);

  logic [INPUT_WIDTH-1:0]   pend_q, pend_d;
  logic                     valid_q, valid_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [SEL_W-1:0]         ptr_q, ptr_d;
  logic                     ovf_q, ovf_d;

  logic [2*INPUT_WIDTH-1:0] dbl;
  logic [INPUT_WIDTH-1:0]   enc_in;
  logic [SEL_W-1:0]         enc_idx;
  logic                     enc_found;
  logic [SEL_W-1:0]         chosen;
  logic [INPUT_WIDTH-1:0]   load_mask;
  logic [INPUT_WIDTH-1:0]   sampled;
  logic                     free;
  logic                     load;
  int                       sum;

  // Round-robin: rotate P right by ptr+1 so the search starts just after the
  // last issued index; the doubled vector makes the shift a rotation.
  always_comb begin
    dbl    = {pend_q, pend_q} >> (int'(ptr_q) + 1);
    enc_in = ROUND_ROBIN ? dbl[INPUT_WIDTH-1:0] : pend_q;
  end

  priority_encoder #(.INPUT_WIDTH(INPUT_WIDTH)) u_enc (
    .data_i  (enc_in),
    .index_o (enc_idx),
    .found_o (enc_found)
  );

  always_comb begin
    sum    = 0;
    chosen = enc_idx;
    if (ROUND_ROBIN) begin
      sum = int'(enc_idx) + int'(ptr_q) + 1;
      if (sum >= INPUT_WIDTH) sum = sum - INPUT_WIDTH;
      chosen = SEL_W'(sum);
    end
  end

  always_comb begin
    free    = !valid_q || ready_i;
    load    = free && enc_found && !clear_i;
    sampled = enable_i ? data_i : '0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      load_mask[i] = load && (chosen == SEL_W'(i));
    end

    pend_d  = (pend_q & ~load_mask) | sampled;
    // The loaded bit has already left P, so re-asserting it is a fresh event.
    ovf_d   = |(sampled & pend_q & ~load_mask);
    valid_d = free ? enc_found : valid_q;
    sel_d   = load ? chosen : sel_q;
    ptr_d   = load ? chosen : ptr_q;

    if (clear_i) begin
      pend_d  = '0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      ptr_q   <= SEL_W'(INPUT_WIDTH - 1);
      ovf_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign select_o   = sel_q;
  assign valid_o    = valid_q;
  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_pending_encoder.sv
// tb/tb_pending_encoder.sv - directed self-checking bench for pending_encoder
module tb_pending_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic [7:0] data = 8'h00;
  logic       clear = 1'b0;
  logic       ready = 1'b1;

  logic [2:0] sel_f, sel_r;
  logic       val_f, val_r, ovf_f, ovf_r;
  logic [7:0] pend_f, pend_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pending_encoder #(.INPUT_WIDTH(8), .ROUND_ROBIN(1'b0)) u_fix (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .data_i(data), .clear_i(clear),
    .select_o(sel_f), .valid_o(val_f), .ready_i(ready), .pending_o(pend_f),
    .overflow_o(ovf_f)
  );

  pending_encoder #(.INPUT_WIDTH(8), .ROUND_ROBIN(1'b1)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .data_i(data), .clear_i(clear),
    .select_o(sel_r), .valid_o(val_r), .ready_i(ready), .pending_o(pend_r),
    .overflow_o(ovf_r)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; data = 8'h00; clear = 1'b0; ready = 1'b1; enable = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({val_f, sel_f, pend_f, ovf_f} !== 13'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d got v=%b s=%0d p=%h o=%b exp 0/0/00/0", i, val_f, sel_f, pend_f, ovf_f);
      end
      tick();
    end
  endtask

  task automatic test_single();
    data = 8'b0010_0000; tick(); data = 8'h00;
    checks++;
    if ({val_f, pend_f} !== {1'b0, 8'h20}) begin
      errors++; $display("FAIL single_capture got v=%b p=%h exp 0/20", val_f, pend_f);
    end
    tick();
    checks++;
    if ({val_f, sel_f, pend_f} !== {1'b1, 3'd5, 8'h00}) begin
      errors++; $display("FAIL single_issue got v=%b s=%0d p=%h exp 1/5/00", val_f, sel_f, pend_f);
    end
    tick();
    checks++;
    if (val_f !== 1'b0) begin
      errors++; $display("FAIL single_once got v=%b exp 0", val_f);
    end
  endtask

  task automatic test_fixed_order();
    logic [2:0] exp_s [3] = '{3'd1, 3'd4, 3'd7};
    logic [7:0] exp_p [3] = '{8'h90, 8'h80, 8'h00};
    data = 8'b1001_0010; tick(); data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({val_f, sel_f, pend_f} !== {1'b1, exp_s[i], exp_p[i]}) begin
        errors++;
        $display("FAIL fixed_order step %0d got v=%b s=%0d p=%h exp 1/%0d/%h", i, val_f, sel_f, pend_f, exp_s[i], exp_p[i]);
      end
    end
    tick();
    checks++;
    if (val_f !== 1'b0) begin
      errors++; $display("FAIL fixed_drain got v=%b exp 0", val_f);
    end
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    data = 8'b0000_0100; tick();
    data = 8'b0000_0001; tick();
    data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({val_f, sel_f, pend_f} !== {1'b1, 3'd2, 8'h01}) begin
        errors++; $display("FAIL bp_hold cycle %0d got v=%b s=%0d p=%h exp 1/2/01", i, val_f, sel_f, pend_f);
      end
      tick();
    end
    ready = 1'b1;
    tick();
    checks++;
    if ({val_f, sel_f, pend_f} !== {1'b1, 3'd0, 8'h00}) begin
      errors++; $display("FAIL bp_release got v=%b s=%0d p=%h exp 1/0/00", val_f, sel_f, pend_f);
    end
    tick();
    checks++;
    if (val_f !== 1'b0) begin
      errors++; $display("FAIL bp_drain got v=%b exp 0", val_f);
    end
  endtask

  task automatic test_round_robin();
    // Expected RR order: 3 | 4,0 (search after 3) | 3,0 (search after 0)
    logic [7:0] pulses [3] = '{8'h08, 8'h11, 8'h09};
    logic [2:0] exp_s  [5] = '{3'd3, 3'd4, 3'd0, 3'd3, 3'd0};
    int k = 0;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      data = pulses[p]; tick(); data = 8'h00;
      for (int n = 0; n < ((p == 0) ? 1 : 2); n++) begin
        tick();
        checks++;
        if ({val_r, sel_r} !== {1'b1, exp_s[k]}) begin
          errors++; $display("FAIL rr_order item %0d got v=%b s=%0d exp 1/%0d", k, val_r, sel_r, exp_s[k]);
        end
        k++;
      end
      tick();
    end
    // Lowest-first instance saw the same stimulus: its second burst starts at 0.
    checks++;
    if (val_f !== 1'b0 || pend_f !== 8'h00) begin
      errors++; $display("FAIL rr_fixed_idle got v=%b p=%h exp 0/00", val_f, pend_f);
    end
  endtask

  task automatic test_overflow();
    ready = 1'b0;
    data = 8'h02; tick(); data = 8'h00; tick();
    data = 8'h40; tick();
    checks++;
    if ({ovf_r, pend_r} !== {1'b0, 8'h40}) begin
      errors++; $display("FAIL ovf_first got o=%b p=%h exp 0/40", ovf_r, pend_r);
    end
    tick();
    checks++;
    if ({ovf_r, pend_r} !== {1'b1, 8'h40}) begin
      errors++; $display("FAIL ovf_second got o=%b p=%h exp 1/40", ovf_r, pend_r);
    end
    // Re-hitting the index held in the stage is not an overflow.
    data = 8'h02; tick();
    checks++;
    if ({ovf_r, pend_r, val_r, sel_r} !== {1'b0, 8'h42, 1'b1, 3'd1}) begin
      errors++; $display("FAIL ovf_stage got o=%b p=%h v=%b s=%0d exp 0/42/1/1", ovf_r, pend_r, val_r, sel_r);
    end
    data = 8'h00; ready = 1'b1; tick();
    checks++;
    if ({val_r, sel_r, pend_r} !== {1'b1, 3'd6, 8'h02}) begin
      errors++; $display("FAIL ovf_issue6 got v=%b s=%0d p=%h exp 1/6/02", val_r, sel_r, pend_r);
    end
    tick();
    checks++;
    if ({val_r, sel_r, pend_r} !== {1'b1, 3'd1, 8'h00}) begin
      errors++; $display("FAIL ovf_once got v=%b s=%0d p=%h exp 1/1/00", val_r, sel_r, pend_r);
    end
    tick();
  endtask

  task automatic test_clear_and_reset();
    do_reset();
    ready = 1'b0;
    data = 8'h01; tick();
    data = 8'hF0; tick();
    data = 8'h00;
    checks++;
    if ({val_f, sel_f, pend_f} !== {1'b1, 3'd0, 8'hF0}) begin
      errors++; $display("FAIL clr_setup got v=%b s=%0d p=%h exp 1/0/F0", val_f, sel_f, pend_f);
    end
    clear = 1'b1; ready = 1'b1; data = 8'h0F; tick();
    clear = 1'b0; data = 8'h00;
    checks++;
    if ({val_f, pend_f, ovf_f} !== {1'b0, 8'h00, 1'b0}) begin
      errors++; $display("FAIL clr_flush got v=%b p=%h o=%b exp 0/00/0", val_f, pend_f, ovf_f);
    end
    tick();
    checks++;
    if ({val_f, pend_f} !== {1'b0, 8'h00}) begin
      errors++; $display("FAIL clr_discard got v=%b p=%h exp 0/00", val_f, pend_f);
    end
    data = 8'h07; tick(); data = 8'h00; tick();
    checks++;
    if ({val_f, sel_f, pend_f} !== {1'b1, 3'd0, 8'h06}) begin
      errors++; $display("FAIL rst_setup got v=%b s=%0d p=%h exp 1/0/06", val_f, sel_f, pend_f);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({val_f, sel_f, pend_f, val_r, pend_r} !== 21'd0) begin
      errors++; $display("FAIL rst_async got v=%b s=%0d p=%h rv=%b rp=%h exp all 0", val_f, sel_f, pend_f, val_r, pend_r);
    end
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();
    checks++;
    if ({val_f, pend_f} !== {1'b0, 8'h00}) begin
      errors++; $display("FAIL rst_lost got v=%b p=%h exp 0/00", val_f, pend_f);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fixed_order();
    test_backpressure();
    test_round_robin();
    test_overflow();
    test_clear_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
